bsa_ram_loader: RTL and testbench

Upstream fill stage for the binary-search datapath. It accepts a stream of 32 bytes over a valid/ready handshake and writes them in arrival order to addresses 0..31 of the 32x8 search RAM through its write port. While loading, it checks that the sequence is non-decreasing. When the last write has been issued, it raises `Done` and reports `Sorted`; the top level gates the search's `start` with `Done && Sorted`.

---
 rtl/bsa_ram_loader.sv | 83 ++++++++
 tb/tb_bsa_ram_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsa_ram_loader.sv
// Fill stage for the binary-search RAM: accepts DEPTH bytes over valid/ready,
// writes them to addresses 0..DEPTH-1 and tracks whether the stream is non-decreasing.
module bsa_ram_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wren,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [AW:0]   Count,
  output logic          Done,
  output logic          Sorted
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  state_t        state;
  logic [DW-1:0] prev;
  logic          accept;

  always_comb begin
    in_ready = (state == S_LOAD);
    accept   = in_ready & in_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      wren    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      Count   <= '0;
      Done    <= 1'b0;
      Sorted  <= 1'b0;
      prev    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          wren <= 1'b0;
          if (load) begin
            state  <= S_LOAD;
            Count  <= '0;
            Sorted <= 1'b1;
            Done   <= 1'b0;
          end
        end
        S_LOAD: begin
          wren <= accept;
          if (accept) begin
            wr_addr <= Count[AW-1:0];
            wr_data <= in_data;
            Count   <= Count + (AW+1)'(1);
            prev    <= in_data;
            // first byte has no predecessor; prev is stale from the last fill
            if (Count != '0 && in_data < prev)
              Sorted <= 1'b0;
            if (Count == LAST)
              state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wren  <= 1'b0;
          Done  <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          wren  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsa_ram_loader.sv
// Randomized bench for bsa_ram_loader: drives fills with assorted gap patterns and
// checks the write port, counters and flags against a per-fill reference of the byte stream.
module tb_bsa_ram_loader;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wren;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   Count;
  logic          Done;
  logic          Sorted;

  bsa_ram_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .load(load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data),
    .Count(Count), .Done(Done), .Sorted(Sorted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ram [DEPTH];   // search RAM as seen through the write port
  logic [DW-1:0] pat [DEPTH];   // byte stream of the current fill

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wren === 1'b1) ram[wr_addr] = wr_data;
  endtask

  function automatic logic prefix_sorted(input int n);
    for (int i = 1; i < n; i++)
      if (pat[i] < pat[i-1]) return 1'b0;
    return 1'b1;
  endfunction

  // mode 0: back-to-back, 1: gap before every beat, 2: random gaps
  task automatic fill(input int n, input int mode, input bit noise, input string name,
                      output int lat);
    int k;
    int cyc;
    bit v;
    k = 0;
    cyc = 0;
    lat = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 'x;
    load = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    in_data = DW'($urandom);
    step();
    load = 1'b0;
    chk({name, "_start_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_start_done"}, 32'(Done), 32'd0);
    chk({name, "_start_count"}, 32'(Count), 32'd0);
    chk({name, "_start_wren"}, 32'(wren), 32'd0);
    while (k < n && cyc < 500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_data  = v ? pat[k] : DW'($urandom);
      load     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
      if (v) begin
        chk({name, "_wren"}, 32'(wren), 32'd1);
        chk({name, "_addr"}, 32'(wr_addr), 32'(k));
        chk({name, "_data"}, 32'(wr_data), 32'(pat[k]));
        chk({name, "_count"}, 32'(Count), 32'(k + 1));
        chk({name, "_sorted_run"}, 32'(Sorted), 32'(prefix_sorted(k + 1)));
        k++;
      end else begin
        chk({name, "_gap_wren"}, 32'(wren), 32'd0);
      end
      chk({name, "_done_early"}, 32'(Done), 32'd0);
    end
    in_valid = 1'b0;
    load = 1'b0;
    if (k < n) chk({name, "_timeout_beats"}, 32'(k), 32'(n));
    if (n == DEPTH) begin
      load = noise;
      in_valid = 1'b1;
      chk({name, "_wait_ready"}, 32'(in_ready), 32'd0);
      step();
      load = 1'b0;
      in_valid = 1'b0;
      lat = cyc + 1;
      chk({name, "_done"}, 32'(Done), 32'd1);
      chk({name, "_done_wren"}, 32'(wren), 32'd0);
      chk({name, "_done_ready"}, 32'(in_ready), 32'd0);
      chk({name, "_done_count"}, 32'(Count), 32'(DEPTH));
      chk({name, "_sorted"}, 32'(Sorted), 32'(prefix_sorted(DEPTH)));
      for (int i = 0; i < DEPTH; i++)
        chk({name, "_ram"}, 32'(ram[i]), 32'(pat[i]));
    end
  endtask

  task automatic hold_done(input logic exp_sorted);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = DW'($urandom);
      step();
      chk("hold_done", 32'(Done), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_wren", 32'(wren), 32'd0);
      chk("hold_count", 32'(Count), 32'(DEPTH));
      chk("hold_sorted", 32'(Sorted), 32'(exp_sorted));
    end
    in_valid = 1'b0;
  endtask

  task automatic random_pattern();
    int acc;
    acc = int'($urandom_range(0, 40));
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 9) == 0) acc = int'($urandom_range(0, 255));
      else acc = acc + int'($urandom_range(0, 8));
      if (acc > 255) acc = 255;
      pat[i] = DW'(acc);
    end
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ready"}, 32'(in_ready), 32'd0);
    chk({name, "_wren"}, 32'(wren), 32'd0);
    chk({name, "_addr"}, 32'(wr_addr), 32'd0);
    chk({name, "_data"}, 32'(wr_data), 32'd0);
    chk({name, "_count"}, 32'(Count), 32'd0);
    chk({name, "_done"}, 32'(Done), 32'd0);
    chk({name, "_sorted"}, 32'(Sorted), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;

    in_valid = 1'b1;
    in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_ready", 32'(in_ready), 32'd0);
      chk("idle_wren", 32'(wren), 32'd0);
      chk("idle_count", 32'(Count), 32'd0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < DEPTH; i++) pat[i] = DW'(2 * i);
    fill(DEPTH, 0, 1'b0, "asc", lat);
    chk("asc_latency", 32'(lat), 32'd33);
    hold_done(1'b1);

    for (int i = 0; i < DEPTH; i++) pat[i] = DW'(2 * i + 2);
    pat[10] = 8'h00;
    fill(DEPTH, 0, 1'b1, "unsorted", lat);
    chk("unsorted_latency", 32'(lat), 32'd33);
    chk("unsorted_flag", 32'(Sorted), 32'd0);

    for (int i = 0; i < DEPTH; i++) pat[i] = 8'h7F;
    fill(DEPTH, 1, 1'b0, "dup", lat);
    chk("dup_latency", 32'(lat), 32'd65);
    chk("dup_flag", 32'(Sorted), 32'd1);

    for (int i = 0; i < DEPTH; i++) pat[i] = DW'(255 - i);
    fill(DEPTH, 2, 1'b1, "desc", lat);
    chk("desc_flag", 32'(Sorted), 32'd0);
    hold_done(1'b0);

    for (int r = 0; r < 4; r++) begin
      random_pattern();
      fill(DEPTH, 2, 1'b1, "rand", lat);
    end

    random_pattern();
    fill(12, 0, 1'b0, "partial", lat);
    #3;
    reset = 1'b0;
    #1;
    check_reset_state("async_reset");
    step();
    step();
    reset = 1'b1;
    in_valid = 1'b1;
    step();
    chk("post_reset_ready", 32'(in_ready), 32'd0);
    chk("post_reset_wren", 32'(wren), 32'd0);
    in_valid = 1'b0;
    random_pattern();
    fill(DEPTH, 2, 1'b0, "refill", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
